// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: load-use bubbles,
// taken-branch flushes, data-memory wait freeze with timeout, stall/flush counters.
module hazard_ctrl #(
    parameter int REGIDX      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REGIDX-1:0] id_rs1,
    input  logic [REGIDX-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REGIDX-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WC_W-1:0]   wait_cnt_r;
    logic [WC_W-1:0]   wait_nxt_s;
    logic              err_set_s;
    logic              mem_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic              lu_s;
    logic              frz_s;
    logic              pc_en_s;
    logic              ifid_en_s;
    logic              ifid_flush_s;
    logic              idex_en_s;
    logic              idex_flush_s;
    logic              exmem_en_s;

    // Hazard detection: load-use match and memory-wait freeze
    always_comb begin
        lu_s  = ex_memread && ex_regwrite && (ex_rd != {REGIDX{1'b0}}) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        frz_s = ((state_r == RUN) && mem_req && !mem_ready) ||
                ((state_r == MEM_WAIT) && !mem_ready && (wait_cnt_r < WC_LAST));
    end

    // Pipeline register controls; freeze holds pending branch/load-use until release
    always_comb begin
        pc_en_s      = 1'b0;
        ifid_en_s    = 1'b0;
        ifid_flush_s = 1'b0;
        idex_en_s    = 1'b0;
        idex_flush_s = 1'b0;
        exmem_en_s   = 1'b0;
        if (rst) begin
            pc_en_s = 1'b0;
        end else if (frz_s) begin
            pc_en_s = 1'b0;
        end else if (ex_br_taken) begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            ifid_flush_s = 1'b1;
            idex_en_s    = 1'b1;
            idex_flush_s = 1'b1;
            exmem_en_s   = 1'b1;
        end else if (lu_s) begin
            idex_en_s    = 1'b1;
            idex_flush_s = 1'b1;
            exmem_en_s   = 1'b1;
        end else begin
            pc_en_s    = 1'b1;
            ifid_en_s  = 1'b1;
            idex_en_s  = 1'b1;
            exmem_en_s = 1'b1;
        end
    end

    // Next-state logic for the memory-wait tracker, including timeout abort
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        err_set_s   = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt_s = MEM_WAIT;
                    wait_nxt_s  = {WC_W{1'b0}};
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_r < WC_LAST) begin
                    wait_nxt_s = wait_cnt_r + WC_W'(1);
                end else begin
                    state_nxt_s = RUN;
                    err_set_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = RUN;
                wait_nxt_s  = {WC_W{1'b0}};
            end
        endcase
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= {WC_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            mem_err_r  <= mem_err_r | err_set_s;
        end
    end

    // Saturating stall and flush counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign pc_en      = pc_en_s;
    assign ifid_en    = ifid_en_s;
    assign ifid_flush = ifid_flush_s;
    assign idex_en    = idex_en_s;
    assign idex_flush = idex_flush_s;
    assign exmem_en   = exmem_en_s;
    assign mem_err    = mem_err_r;
    assign stall_cnt  = stall_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences,
// expectations queued at drive time and compared at the falling edge.
module tb_hazard_ctrl;

    // output vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
    localparam logic [5:0] O_RUN = 6'b110101;
    localparam logic [5:0] O_FRZ = 6'b000000;
    localparam logic [5:0] O_BR  = 6'b111111;
    localparam logic [5:0] O_LU  = 6'b000111;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic       mq;
        logic       my;
        logic [5:0] outs;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic [5:0]  outs;
        logic        err;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_regwrite = 1'b0;
    logic        ex_memread = 1'b0, ex_br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_mem_err;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int   errors = 0;
    int   checks = 0;
    int   model_stall = 0;
    int   model_flush = 0;
    exp_t exp_q[$];
    vec_t tbl[11];

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
        .ifid_flush(s_ifid_flush), .idex_en(s_idex_en), .idex_flush(s_idex_flush),
        .exmem_en(s_exmem_en), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input int rs1, input int rs2, input int u1, input int u2,
                                 input int rd, input int rw, input int mr, input int br,
                                 input int mq, input int my, input logic [5:0] outs, input int err);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
        v.rd = 5'(rd); v.rw = 1'(rw); v.mr = 1'(mr); v.br = 1'(br);
        v.mq = 1'(mq); v.my = 1'(my); v.outs = outs; v.err = 1'(err);
        return v;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] sat15(input logic [31:0] x);
        return (x > 32'd15) ? 32'd15 : x;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_rd = v.rd; ex_regwrite = v.rw; ex_memread = v.mr; ex_br_taken = v.br;
        mem_req = v.mq; mem_ready = v.my;
    endtask

    task automatic step(input vec_t v, input string nm);
        exp_t e;
        drive(v);
        exp_q.push_back({v.outs, v.err, 32'(model_stall), 32'(model_flush)});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({nm, ".outs"}, 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}), 32'(e.outs));
        chk({nm, ".sat_outs"}, 32'({s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en}), 32'(e.outs));
        chk({nm, ".mem_err"}, 32'(mem_err), 32'(e.err));
        chk({nm, ".stall_cnt"}, 32'(stall_cnt), e.stall);
        chk({nm, ".flush_cnt"}, 32'(flush_cnt), e.flush);
        chk({nm, ".sat_stall"}, 32'(s_stall_cnt), sat15(e.stall));
        chk({nm, ".sat_flush"}, 32'(s_flush_cnt), sat15(e.flush));
        if (e.outs[5] == 1'b0) model_stall++;
        if (e.outs[3] == 1'b1) model_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, ".outs"}, 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}), 32'(O_FRZ));
        chk({nm, ".mem_err"}, 32'(mem_err), 32'd0);
        chk({nm, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({nm, ".flush_cnt"}, 32'(flush_cnt), 32'd0);
        chk({nm, ".sat_stall"}, 32'(s_stall_cnt), 32'd0);
    endtask

    initial begin
        tbl[0]  = mkv(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, O_LU, 0);    // load-use on rs1
        tbl[1]  = mkv(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, O_RUN, 0);   // x0 never hazards
        tbl[2]  = mkv(5, 0, 1, 0, 5, 1, 1, 1, 0, 0, O_BR, 0);    // branch beats load-use
        tbl[3]  = mkv(0, 7, 0, 1, 7, 1, 1, 0, 0, 0, O_LU, 0);    // load-use on rs2
        tbl[4]  = mkv(5, 0, 0, 0, 5, 1, 1, 0, 0, 0, O_RUN, 0);   // rs1 not read
        tbl[5]  = mkv(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, O_RUN, 0);   // not a load
        tbl[6]  = mkv(5, 0, 1, 0, 5, 0, 1, 0, 0, 0, O_RUN, 0);   // no regwrite
        tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR, 0);    // plain taken branch
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN, 0);   // zero-wait access
        tbl[9]  = mkv(4, 6, 1, 1, 5, 1, 1, 0, 0, 0, O_RUN, 0);   // index mismatch
        tbl[10] = mkv(3, 31, 1, 1, 31, 1, 1, 0, 0, 0, O_LU, 0);  // rd=31 boundary

        ex_br_taken = 1'b1;
        #2;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        ex_br_taken = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // three wait cycles then ready
        for (int i = 0; i < 3; i++) step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0), "wait3_frz");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN, 0), "wait3_release");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0), "wait3_idle");

        // branch and load-use held through a freeze
        step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ, 0), "frz_br");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_BR, 0), "frz_br_release");
        step(mkv(5, 0, 1, 0, 5, 1, 1, 0, 1, 0, O_FRZ, 0), "frz_lu");
        step(mkv(5, 0, 1, 0, 5, 1, 1, 0, 0, 1, O_LU, 0), "frz_lu_release");

        // timeout: 16 frozen cycles, abort release, sticky error
        for (int i = 0; i < 16; i++) step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0), $sformatf("tmo_frz%0d", i));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN, 0), "tmo_abort");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 1), "tmo_err");
        step(mkv(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, O_LU, 1), "tmo_err_lu");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN, 1), "tmo_err_zw");

        // reset asserted mid MEM_WAIT
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 1), "rstmw_frz0");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 1), "rstmw_frz1");
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ, 0));
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst_async");
        @(negedge clk);
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0));
        rst = 1'b0;
        model_stall = 0;
        model_flush = 0;
        @(posedge clk);
        #1;
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0), "post_rst_run");

        // drive the 4-bit counters into saturation
        for (int i = 0; i < 20; i++) step(mkv(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, O_LU, 0), $sformatf("sat_lu%0d", i));
        for (int i = 0; i < 18; i++) step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR, 0), $sformatf("sat_br%0d", i));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0), "sat_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Drives the enable and flush (bubble) inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers from the ID/EX register outputs and the data-memory handshake.
- Handles three hazards: load-use, taken branch/jump, and multi-cycle data-memory wait.
- Sequential content: a RUN/MEM_WAIT state machine with timeout, a sticky error flag, and saturating stall/flush performance counters.

Parameters:
- REGIDX, 5, register index width.
- MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before abort.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  REGIDX  rs1 index of the instruction in ID.
- id_rs2  in  REGIDX  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REGIDX  destination register at the ID/EX output.
- ex_regwrite  in  1  Regwrite at the ID/EX output.
- ex_memread  in  1  EX instruction is a load (Wbsel selects memory data).
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM stage is accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_en  out  1  ID/EX enable.
- idex_flush  out  1  ID/EX clear to bubble (all control fields 0).
- exmem_en  out  1  EX/MEM enable.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, all enables=0 and both flushes=0.
- Outputs are combinational from state and inputs. The state, wait counter and statistics counters are registered on the rising edge of clk.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_memread=1, ex_regwrite=1, ex_rd!=0;
  - (id_use_rs1=1 and id_rs1==ex_rd) or (id_use_rs2=1 and id_rs2==ex_rd).
- Freeze condition (frz): (state==RUN and mem_req=1 and mem_ready=0) or (state==MEM_WAIT and mem_ready=0 and wait_cnt<MEM_TIMEOUT-1).
- Output priority (first matching row wins):
  1. frz: pc_en=ifid_en=idex_en=exmem_en=0, no flush. A pending ex_br_taken or lu is held and re-evaluated after the freeze.
  2. ex_br_taken: all enables=1, ifid_flush=1, idex_flush=1. Flush beats load-use because the ID instruction is squashed.
  3. lu: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. Exactly one bubble; the next cycle the load is in MEM and lu clears.
  4. Otherwise: all enables=1, no flush.
- State machine:
  - RUN -> MEM_WAIT when mem_req=1 and mem_ready=0; wait_cnt<=0.
  - MEM_WAIT, mem_ready=1: -> RUN. The freeze releases in this same cycle.
  - MEM_WAIT, mem_ready=0, wait_cnt<MEM_TIMEOUT-1: stay; wait_cnt++.
  - MEM_WAIT, mem_ready=0, wait_cnt==MEM_TIMEOUT-1: -> RUN, mem_err<=1. The pipeline is released in this cycle (abort).
- Freeze duration: a single access stalls for at most MEM_TIMEOUT cycles.
- mem_err is cleared only by rst.
- stall_cnt increments when pc_en=0 and rst=0; flush_cnt increments when ifid_flush=1. Both saturate at 2^CNT_W-1 and never wrap.
- mem_req=1 with mem_ready=1 in RUN: no stall, zero-wait access.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters and mem_err cleared.

Test Plan:
1. Load-use: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt 0->1.
2. ex_rd=0 with id_rs1=0, all other load-use conditions true -> no stall, all enables=1.
3. ex_br_taken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_en=1; flush_cnt +1, stall_cnt unchanged.
4. mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> all enables 0 for 3 cycles, release on the 4th cycle, state back to RUN, stall_cnt=3.
5. mem_req=1, mem_ready never asserted, MEM_TIMEOUT=16 -> freeze for exactly 16 cycles, then release with mem_err=1 sticky until rst.
6. rst pulsed during MEM_WAIT, and separately stall_cnt forced to saturation with CNT_W=4 -> reset clears outputs asynchronously; the saturated counter holds at 15.
